boot_mem: RTL and testbench

- Memory responder on the far side of the 6502 core's fetch bus. Returns `rd_data` for the core's registered `address` in the same cycle (zero wait state).
- Owns a byte RAM, the six-byte vector page (`$FFFA`–`$FFFF`) and a byte-stream loader.
- The loader fills memory while the core is held in reset, then releases the core's `resetn`.

---
 rtl/boot_mem_pkg.sv | 43 ++++
 rtl/boot_mem_ram.sv | 30 +++
 rtl/boot_mem.sv | 190 +++++++++++++++++++
 tb/tb_boot_mem.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_mem_pkg.sv
// ============================================================
// boot_mem_pkg : loader FSM state encoding and vector-page map
// Revision     : 1.0
// ============================================================
`default_nettype none

package boot_mem_pkg;

    localparam int STATE_W    = 7;
    localparam int HOLD_IDX   = 0;
    localparam int RUN_IDX    = 1;
    localparam int ADDR_L_IDX = 2;
    localparam int ADDR_H_IDX = 3;
    localparam int LEN_L_IDX  = 4;
    localparam int LEN_H_IDX  = 5;
    localparam int DATA_IDX   = 6;

    typedef enum logic [STATE_W-1:0] {
        ST_HOLD   = STATE_W'(1) << HOLD_IDX,
        ST_RUN    = STATE_W'(1) << RUN_IDX,
        ST_ADDR_L = STATE_W'(1) << ADDR_L_IDX,
        ST_ADDR_H = STATE_W'(1) << ADDR_H_IDX,
        ST_LEN_L  = STATE_W'(1) << LEN_L_IDX,
        ST_LEN_H  = STATE_W'(1) << LEN_H_IDX,
        ST_DATA   = STATE_W'(1) << DATA_IDX
    } state_e;

    localparam int          NUM_VEC   = 6;
    localparam logic [15:0] VEC_BASE  = 16'hFFFA;
    localparam logic [15:0] NMI_LSB   = 16'hFFFA;
    localparam logic [15:0] NMI_MSB   = 16'hFFFB;
    localparam logic [15:0] RESET_LSB = 16'hFFFC;
    localparam logic [15:0] RESET_MSB = 16'hFFFD;
    localparam logic [15:0] IRQ_LSB   = 16'hFFFE;
    localparam logic [15:0] IRQ_MSB   = 16'hFFFF;

    function automatic logic is_vec(input logic [15:0] a);
        return a >= VEC_BASE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/boot_mem_ram.sv
// ============================================================
// boot_mem_ram : byte RAM, one write port, asynchronous read
// Revision     : 1.0
// ============================================================
`default_nettype none

module boot_mem_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    logic [7:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

`default_nettype wire

// File: rtl/boot_mem.sv
// ============================================================
// boot_mem : zero-wait fetch responder with byte-stream loader
// Revision : 1.0
// ============================================================
`default_nettype none

module boot_mem
    import boot_mem_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [15:0] RESET_VEC = 16'h0200,
    parameter logic [7:0]  FILL      = 8'hEA,
    parameter int          HOLD_CYC  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    output logic [7:0]  rd_data,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    output logic        load_ready,
    output logic        cpu_resetn,
    output logic        load_done,
    output logic        load_err
);

    state_e                    state_q, state_d;
    logic [7:0]                hold_cnt_q, hold_cnt_d;
    logic                      from_load_q, from_load_d;
    logic [15:0]               ptr_q, ptr_d;
    logic [15:0]               len_q, len_d;
    logic                      cpu_resetn_q, cpu_resetn_d;
    logic                      load_done_q, load_done_d;
    logic                      load_err_q, load_err_d;
    logic [NUM_VEC-1:0][7:0]   vec_q, vec_d;

    logic                      xfer;
    logic                      ram_we;
    logic [7:0]                ram_rd;
    logic [7:0]                vec_rd;

    function automatic logic in_ram(input logic [15:0] a);
        return (32'(a) >> ADDR_W) == 32'd0;
    endfunction

    boot_mem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (ram_we),
        .i_waddr (ptr_q[ADDR_W-1:0]),
        .i_wdata (load_data),
        .i_raddr (address[ADDR_W-1:0]),
        .o_rdata (ram_rd)
    );

    always_comb begin
        vec_rd = FILL;
        for (int i = 0; i < NUM_VEC; i++) begin
            if (address == VEC_BASE + 16'(i)) begin
                vec_rd = vec_q[i];
            end
        end
    end

    assign rd_data    = in_ram(address) ? ram_rd : vec_rd;
    assign load_ready = |state_q[DATA_IDX:ADDR_L_IDX];
    assign xfer       = load_valid && load_ready;

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        from_load_d = from_load_q;
        ptr_d       = ptr_q;
        len_d       = len_q;
        load_err_d  = load_err_q;
        load_done_d = 1'b0;
        vec_d       = vec_q;
        ram_we      = 1'b0;

        case (state_q)
            ST_HOLD: begin
                if (hold_cnt_q <= 8'd1) begin
                    state_d     = ST_RUN;
                    load_done_d = from_load_q;
                    from_load_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end
            end
            ST_RUN: begin
                if (load_start) begin
                    state_d    = ST_ADDR_L;
                    load_err_d = 1'b0;
                end
            end
            ST_ADDR_L: begin
                if (xfer) begin
                    ptr_d[7:0] = load_data;
                    state_d    = ST_ADDR_H;
                end
            end
            ST_ADDR_H: begin
                if (xfer) begin
                    ptr_d[15:8] = load_data;
                    state_d     = ST_LEN_L;
                end
            end
            ST_LEN_L: begin
                if (xfer) begin
                    len_d[7:0] = load_data;
                    state_d    = ST_LEN_H;
                end
            end
            ST_LEN_H: begin
                if (xfer) begin
                    len_d = {load_data, len_q[7:0]};
                    if (len_d == 16'd0) begin
                        state_d     = ST_HOLD;
                        hold_cnt_d  = 8'(HOLD_CYC);
                        from_load_d = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    if (in_ram(ptr_q)) begin
                        ram_we = 1'b1;
                    end else if (is_vec(ptr_q)) begin
                        for (int i = 0; i < NUM_VEC; i++) begin
                            if (ptr_q == VEC_BASE + 16'(i)) begin
                                vec_d[i] = load_data;
                            end
                        end
                    end else begin
                        load_err_d = 1'b1;
                    end
                    ptr_d = ptr_q + 16'd1;
                    len_d = len_q - 16'd1;
                    if (len_q == 16'd1) begin
                        state_d     = ST_HOLD;
                        hold_cnt_d  = 8'(HOLD_CYC);
                        from_load_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = ST_HOLD;
                hold_cnt_d = 8'(HOLD_CYC);
            end
        endcase

        // The core sees reset released exactly when the FSM lands in RUN.
        cpu_resetn_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_HOLD;
            hold_cnt_q   <= 8'(HOLD_CYC);
            from_load_q  <= 1'b0;
            ptr_q        <= 16'd0;
            len_q        <= 16'd0;
            cpu_resetn_q <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            vec_q        <= {RESET_VEC, RESET_VEC, RESET_VEC};
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            from_load_q  <= from_load_d;
            ptr_q        <= ptr_d;
            len_q        <= len_d;
            cpu_resetn_q <= cpu_resetn_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
            vec_q        <= vec_d;
        end
    end

    assign cpu_resetn = cpu_resetn_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;

endmodule

`default_nettype wire

// File: tb/tb_boot_mem.sv
// ============================================================
// tb_boot_mem : directed + randomized loads against a memory-map model
// Revision    : 1.0
// ============================================================
`default_nettype none

module tb_boot_mem;

    localparam int          ADDR_W    = 12;
    localparam logic [15:0] RESET_VEC = 16'h0200;
    localparam logic [7:0]  FILL      = 8'hEA;
    localparam int          HOLD_CYC  = 4;
    localparam int          RAM_SZ    = 2**ADDR_W;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] address = 16'h0000;
    logic [7:0]  rd_data;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_data = 8'h00;
    logic        load_ready;
    logic        cpu_resetn;
    logic        load_done;
    logic        load_err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ref_ram [RAM_SZ];
    bit          ref_ok  [RAM_SZ];
    logic [7:0]  ref_vec [6];
    bit          ref_err;
    logic [7:0]  pay [$];
    logic [15:0] touched [$];

    always #5 clk = ~clk;

    boot_mem #(
        .ADDR_W    (ADDR_W),
        .RESET_VEC (RESET_VEC),
        .FILL      (FILL),
        .HOLD_CYC  (HOLD_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .rd_data    (rd_data),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .cpu_resetn (cpu_resetn),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural map: what a read of address a should return.
    function automatic logic [7:0] ref_read(input logic [15:0] a);
        if (int'(a) < RAM_SZ) return ref_ram[a];
        if (a >= 16'hFFFA)    return ref_vec[int'(a) - 16'hFFFA];
        return FILL;
    endfunction

    function automatic bit ref_known(input logic [15:0] a);
        if (int'(a) < RAM_SZ) return ref_ok[a];
        return 1'b1;
    endfunction

    task automatic ref_reset();
        for (int i = 0; i < 6; i++) ref_vec[i] = (i % 2 == 0) ? RESET_VEC[7:0] : RESET_VEC[15:8];
        ref_err = 1'b0;
    endtask

    task automatic ref_load(input logic [15:0] start, input int n);
        logic [15:0] t;
        for (int i = 0; i < n; i++) begin
            t = start + 16'(i);
            touched.push_back(t);
            if (int'(t) < RAM_SZ) begin
                ref_ram[t] = pay[i];
                ref_ok[t]  = 1'b1;
            end else if (t >= 16'hFFFA) begin
                ref_vec[int'(t) - 16'hFFFA] = pay[i];
            end else begin
                ref_err = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a);
        address = a;
        #1;
        if (ref_known(a)) chk(tag, rd_data, ref_read(a));
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        load_start = 1'b0;
        load_valid = 1'b0;
        tick();
        reset = 1'b0;
        ref_reset();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        load_data  = b;
        load_valid = 1'b1;
        while (load_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
        tick();
        load_valid = 1'b0;
    endtask

    // Called one step after the edge that entered HOLD with a fresh count.
    task automatic wait_release(input string tag, input bit exp_done);
        int  n = 0;
        bit  early = 1'b0;
        while (cpu_resetn !== 1'b1 && n < 50) begin
            if (load_done === 1'b1) early = 1'b1;
            tick();
            n++;
        end
        chk({tag, "_hold_cycles"}, n, HOLD_CYC);
        chk({tag, "_done_early"}, early, 1'b0);
        chk({tag, "_done_pulse"}, load_done, exp_done);
        tick();
        chk({tag, "_done_once"}, load_done, 1'b0);
        chk({tag, "_run_resetn"}, cpu_resetn, 1'b1);
    endtask

    // Streams header + pay[0..len-1]; abort_after >= 0 stops after that many data bytes.
    task automatic do_load(input string tag, input logic [15:0] start, input int len,
                           input int gapmax, input bit mid_start, input int abort_after);
        int sent;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        ref_err = 1'b0;
        chk({tag, "_resetn_low"}, cpu_resetn, 1'b0);
        chk({tag, "_ready"}, load_ready, 1'b1);
        chk({tag, "_err_clr"}, load_err, 1'b0);
        send_byte(start[7:0]);
        send_byte(start[15:8]);
        send_byte(8'(len));
        send_byte(8'(len >> 8));
        sent = 0;
        for (int i = 0; i < len; i++) begin
            if (abort_after >= 0 && i == abort_after) break;
            repeat ($urandom_range(0, gapmax)) tick();
            if (mid_start && i == len / 2) begin
                load_start = 1'b1;
                tick();
                load_start = 1'b0;
            end
            send_byte(pay[i]);
            sent++;
        end
        ref_load(start, sent);
        if (abort_after < 0) begin
            wait_release(tag, 1'b1);
            chk({tag, "_err"}, load_err, ref_err);
        end
    endtask

    task automatic fill_pay(input int n);
        pay = {};
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] a;
        int          n;

        // Reset with no load
        do_reset();
        chk("rst_resetn", cpu_resetn, 1'b0);
        chk("rst_ready", load_ready, 1'b0);
        chk("rst_done", load_done, 1'b0);
        chk("rst_err", load_err, 1'b0);
        wait_release("boot", 1'b0);
        rd_chk("vec_fffc", 16'hFFFC);
        rd_chk("vec_fffd", 16'hFFFD);
        rd_chk("unmapped_8000", 16'h8000);
        address = 16'hFFFC; #1; chk("rst_vec_lsb", rd_data, 8'h00);
        address = 16'hFFFD; #1; chk("rst_vec_msb", rd_data, 8'h02);
        address = 16'h8000; #1; chk("fill_8000", rd_data, 8'hEA);

        // Program bytes into $0300
        pay = '{8'hA9, 8'h4C, 8'hEA};
        do_load("ld300", 16'h0300, 3, 0, 1'b0, -1);
        for (int i = 0; i < 3; i++) rd_chk("ram_300", 16'h0300 + 16'(i));
        address = 16'h0301; #1; chk("ram_301_lit", rd_data, 8'h4C);

        // Retarget reset vector
        pay = '{8'h00, 8'h03};
        do_load("ldvec", 16'hFFFC, 2, 0, 1'b0, -1);
        address = 16'hFFFC; #1; a[7:0]  = rd_data;
        address = 16'hFFFD; #1; a[15:8] = rd_data;
        chk("fetch_addr", a, 16'h0300);
        rd_chk("vec_fffe", 16'hFFFE);

        // Unwritable target: byte dropped, sticky error
        pay = '{8'h55};
        do_load("lderr", 16'h2000, 1, 0, 1'b0, -1);
        chk("err_set", load_err, 1'b1);
        repeat (3) tick();
        chk("err_sticky", load_err, 1'b1);
        rd_chk("unmapped_2000", 16'h2000);
        rd_chk("ram_300_keep", 16'h0300);

        // Length-0 header clears error and goes straight to HOLD
        pay = {};
        do_load("len0", 16'h0123, 0, 0, 1'b0, -1);

        // Valid gaps plus a stray load_start during DATA
        fill_pay(6);
        do_load("gaps", 16'h0500, 6, 3, 1'b1, -1);
        for (int i = 0; i < 6; i++) rd_chk("ram_500", 16'h0500 + 16'(i));
        rd_chk("ram_506_unw", 16'h0506);

        // Pointer wraps from the vector page into RAM
        fill_pay(4);
        do_load("wrap", 16'hFFFE, 4, 1, 1'b0, -1);
        rd_chk("wrap_fffe", 16'hFFFE);
        rd_chk("wrap_ffff", 16'hFFFF);
        rd_chk("wrap_0000", 16'h0000);
        rd_chk("wrap_0001", 16'h0001);

        // Randomized loads anywhere in the address space
        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, 6);
            fill_pay(n);
            a = (k % 2 == 0) ? 16'($urandom_range(0, RAM_SZ - 1)) : 16'($urandom);
            do_load("rnd", a, n, 2, 1'b0, -1);
        end
        foreach (touched[i]) rd_chk("rnd_rb", touched[i]);
        for (int k = 0; k < 8; k++) rd_chk("rnd_any", 16'($urandom));

        // Reset mid-DATA after 2 of 5 bytes
        fill_pay(5);
        do_load("abort", 16'h0400, 5, 0, 1'b0, 2);
        do_reset();
        chk("abort_ready", load_ready, 1'b0);
        chk("abort_resetn", cpu_resetn, 1'b0);
        chk("abort_err", load_err, 1'b0);
        rd_chk("abort_vec_fffc", 16'hFFFC);
        rd_chk("abort_vec_fffd", 16'hFFFD);
        rd_chk("abort_ram_400", 16'h0400);
        rd_chk("abort_ram_401", 16'h0401);
        wait_release("abort_rel", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
